// File: rtl/per_operand_loader_pkg.sv
// Shared definitions for the bit-permutation operand path: word geometry,
// loader state encodings and frame-size helpers.
package per_defs;

  // Word and byte geometry shared with the permutation stage
  localparam int WORD_W      = 32;
  localparam int IN_W        = 8;
  localparam int WORD_BYTES  = WORD_W / IN_W;
  localparam int FRAME_BYTES = 2 * WORD_BYTES;
  localparam int CNT_W       = $clog2(FRAME_BYTES);

  // Popcount result width: holds 0..32 without wrapping
  localparam int ONES_W = 6;

  // Loader FSM states
  typedef enum logic [1:0] {
    LOAD_X = 2'd0,
    LOAD_Y = 2'd1,
    HOLD   = 2'd2
  } load_state_e;

  // Bytes per frame (X word followed by Y word) for an arbitrary geometry
  function automatic int frame_bytes(input int word_w, input int in_w);
    return 2 * (word_w / in_w);
  endfunction

endpackage

// File: rtl/per_popcount32.sv
// Combinational set-bit counter for the Y control word.
module per_popcount32
  import per_defs::*;
#(
  parameter int W = per_defs::WORD_W
) (
  input  logic [W-1:0]      data_i,
  output logic [ONES_W-1:0] count_o
);

  // Ripple sum of every bit of the word
  always_comb begin
    count_o = '0;
    for (int i = 0; i < W; i++) begin
      count_o = count_o + ONES_W'(data_i[i]);
    end
  end

endmodule

// File: rtl/per_operand_loader.sv
// Byte-stream loader for the permutation stage: assembles X then Y from a
// framed byte stream, flags framing errors, counts ones in Y and presents
// the pair with a valid/ready handshake.
module per_operand_loader
  import per_defs::*;
#(
  parameter int WORD_W    = per_defs::WORD_W,
  parameter int IN_W      = per_defs::IN_W,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [WORD_W-1:0] x_out,
  output logic [WORD_W-1:0] y_out,
  output logic [ONES_W-1:0] ones_cnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_err
);

  localparam int N_WORD  = WORD_W / IN_W;
  localparam int N_FRAME = per_defs::frame_bytes(WORD_W, IN_W);
  localparam int BCNT_W  = $clog2(N_FRAME);

  localparam logic [BCNT_W-1:0] LAST_X_IDX = BCNT_W'(N_WORD - 1);
  localparam logic [BCNT_W-1:0] LAST_IDX   = BCNT_W'(N_FRAME - 1);
  localparam logic [BCNT_W-1:0] CNT_ONE    = BCNT_W'(1);

  load_state_e         state_q, state_d;
  logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [WORD_W-1:0]   x_q, x_d;
  logic [WORD_W-1:0]   y_q, y_d;
  logic [ONES_W-1:0]   ones_q, ones_d;
  logic                out_valid_q, out_valid_d;
  logic                frame_err_q, frame_err_d;

  logic [WORD_W-1:0]   x_shift;
  logic [WORD_W-1:0]   y_shift;
  logic [ONES_W-1:0]   ones_next;
  logic                take;
  logic                final_byte;

  // Candidate register contents with the incoming byte shifted in
  always_comb begin
    if (MSB_FIRST) begin
      x_shift = {x_q[WORD_W-IN_W-1:0], in_data};
      y_shift = {y_q[WORD_W-IN_W-1:0], in_data};
    end else begin
      x_shift = {in_data, x_q[WORD_W-1:IN_W]};
      y_shift = {in_data, y_q[WORD_W-1:IN_W]};
    end
  end

  // Popcount of Y as it will look once the final byte lands, so the
  // count can be registered together with out_valid
  per_popcount32 #(
    .W (WORD_W)
  ) u_popcount (
    .data_i  (y_shift),
    .count_o (ones_next)
  );

  // Byte acceptance: never while held or while reset is asserted
  always_comb begin
    in_ready   = rst && (state_q != HOLD);
    take       = in_valid && in_ready;
    final_byte = (byte_cnt_q == LAST_IDX);
  end

  // Next-state logic: byte counting, framing checks and the output handshake
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    ones_d      = ones_q;
    out_valid_d = out_valid_q;
    frame_err_d = 1'b0;

    case (state_q)
      LOAD_X: begin
        if (take) begin
          if (in_last) begin
            // Early end of frame: drop the partial frame and restart
            frame_err_d = 1'b1;
            byte_cnt_d  = '0;
            state_d     = LOAD_X;
          end else begin
            x_d        = x_shift;
            byte_cnt_d = byte_cnt_q + CNT_ONE;
            if (byte_cnt_q == LAST_X_IDX) begin
              state_d = LOAD_Y;
            end
          end
        end
      end

      LOAD_Y: begin
        if (take) begin
          if (final_byte) begin
            // Frame complete; a missing in_last is flagged but the pair is kept
            y_d         = y_shift;
            ones_d      = ones_next;
            out_valid_d = 1'b1;
            frame_err_d = !in_last;
            state_d     = HOLD;
          end else if (in_last) begin
            frame_err_d = 1'b1;
            byte_cnt_d  = '0;
            state_d     = LOAD_X;
          end else begin
            y_d        = y_shift;
            byte_cnt_d = byte_cnt_q + CNT_ONE;
          end
        end
      end

      HOLD: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          byte_cnt_d  = '0;
          state_d     = LOAD_X;
        end
      end

      default: begin
        state_d     = LOAD_X;
        byte_cnt_d  = '0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= LOAD_X;
      byte_cnt_q  <= '0;
      x_q         <= '0;
      y_q         <= '0;
      ones_q      <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      ones_q      <= ones_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign x_out     = x_q;
  assign y_out     = y_q;
  assign ones_cnt  = ones_q;
  assign out_valid = out_valid_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_per_operand_loader.sv
// Directed and randomised-timing bench for the operand loader.
module tb_per_operand_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] x_out;
  logic [31:0] y_out;
  logic [5:0]  ones_cnt;
  logic        out_valid;
  logic        out_ready;
  logic        frame_err;

  int checks = 0;
  int errors = 0;

  per_operand_loader #(
    .WORD_W    (32),
    .IN_W      (8),
    .MSB_FIRST (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .x_out     (x_out),
    .y_out     (y_out),
    .ones_cnt  (ones_cnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .frame_err (frame_err)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Move to just after the next rising edge, where inputs are changed
  task automatic drive_point();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte after an idle gap and wait (bounded) until it is taken
  task automatic apply_stimulus(input logic [7:0] data, input logic last, input int gap);
    logic accepted;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0;
      drive_point();
    end
    in_data  = data;
    in_last  = last;
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1'b1;
        break;
      end
      drive_point();
    end
    check_output("byte_accepted", {31'd0, accepted}, 32'd1);
    drive_point();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Send the first nbytes of a frame, MSB byte first, with in_last on last_idx
  task automatic send_frame(input logic [63:0] f, input int nbytes, input int last_idx, input int gap_max);
    for (int i = 0; i < nbytes; i++) begin
      apply_stimulus(f[63-8*i -: 8], (i == last_idx),
                     (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
    end
  endtask

  // Hand the held pair downstream, optionally with random out_ready
  task automatic release_hold(input bit rnd);
    logic done;
    done = 1'b0;
    for (int t = 0; t < 80; t++) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (out_valid && out_ready) begin
        done = 1'b1;
        break;
      end
      drive_point();
    end
    drive_point();
    out_ready = 1'b0;
    check_output("handshake_done", {31'd0, done}, 32'd1);
    @(negedge clk);
    check_output("rel_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("rel_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  // Directed sequence followed by randomised-timing frames
  initial begin
    logic [63:0] fr;

    rst       = 1'b1;
    in_data   = 8'h00;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #1 rst = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check_output("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_output("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("rst_x", x_out, 32'd0);
    check_output("rst_y", y_out, 32'd0);
    check_output("rst_ones", {26'd0, ones_cnt}, 32'd0);
    check_output("rst_frame_err", {31'd0, frame_err}, 32'd0);
    drive_point();
    rst = 1'b1;
    @(negedge clk);
    check_output("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic frame
    $display("[TB] basic frame");
    drive_point();
    send_frame(64'hDEADBEEF_0F0F00FF, 8, 7, 0);
    @(negedge clk);
    check_output("t1_out_valid", {31'd0, out_valid}, 32'd1);
    check_output("t1_x", x_out, 32'hDEADBEEF);
    check_output("t1_y", y_out, 32'h0F0F00FF);
    check_output("t1_ones", {26'd0, ones_cnt}, 32'd16);
    check_output("t1_frame_err", {31'd0, frame_err}, 32'd0);

    // Backpressure in HOLD with bytes pending upstream
    $display("[TB] hold backpressure");
    drive_point();
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_output("t2_in_ready", {31'd0, in_ready}, 32'd0);
      check_output("t2_out_valid", {31'd0, out_valid}, 32'd1);
      check_output("t2_x", x_out, 32'hDEADBEEF);
      check_output("t2_y", y_out, 32'h0F0F00FF);
      check_output("t2_ones", {26'd0, ones_cnt}, 32'd16);
      drive_point();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_output("t2_hs_out_valid", {31'd0, out_valid}, 32'd1);
    drive_point();
    out_ready = 1'b0;
    @(negedge clk);
    check_output("t2_rel_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("t2_rel_in_ready", {31'd0, in_ready}, 32'd1);

    // Early in_last aborts the frame
    $display("[TB] early in_last");
    drive_point();
    send_frame(64'h01020300_00000000, 3, 2, 0);
    @(negedge clk);
    check_output("t3_frame_err", {31'd0, frame_err}, 32'd1);
    check_output("t3_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("t3_in_ready", {31'd0, in_ready}, 32'd1);
    drive_point();
    @(negedge clk);
    check_output("t3_err_pulse_end", {31'd0, frame_err}, 32'd0);
    drive_point();
    send_frame(64'h00000000_FFFFFFFF, 8, 7, 0);
    @(negedge clk);
    check_output("t3_out_valid2", {31'd0, out_valid}, 32'd1);
    check_output("t3_x", x_out, 32'h00000000);
    check_output("t3_y", y_out, 32'hFFFFFFFF);
    check_output("t3_ones", {26'd0, ones_cnt}, 32'd32);
    check_output("t3_frame_err2", {31'd0, frame_err}, 32'd0);
    drive_point();
    release_hold(1'b0);

    // Full frame without in_last: delivered and flagged
    $display("[TB] missing in_last");
    drive_point();
    send_frame(64'h12345678_9ABCDEF0, 8, 8, 0);
    @(negedge clk);
    check_output("t4_out_valid", {31'd0, out_valid}, 32'd1);
    check_output("t4_frame_err", {31'd0, frame_err}, 32'd1);
    check_output("t4_x", x_out, 32'h12345678);
    check_output("t4_y", y_out, 32'h9ABCDEF0);
    check_output("t4_ones", {26'd0, ones_cnt}, 32'd19);
    drive_point();
    @(negedge clk);
    check_output("t4_err_pulse_end", {31'd0, frame_err}, 32'd0);
    drive_point();
    release_hold(1'b0);

    // Reset in the middle of a frame
    $display("[TB] mid-frame reset");
    drive_point();
    send_frame(64'hAABBCCDD_EE000000, 5, 8, 0);
    rst = 1'b0;
    #1;
    check_output("t5_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check_output("t5_rst_x", x_out, 32'd0);
    check_output("t5_rst_y", y_out, 32'd0);
    check_output("t5_rst_out_valid", {31'd0, out_valid}, 32'd0);
    drive_point();
    rst = 1'b1;
    send_frame(64'h11223344_00000001, 8, 7, 0);
    @(negedge clk);
    check_output("t5_out_valid", {31'd0, out_valid}, 32'd1);
    check_output("t5_x", x_out, 32'h11223344);
    check_output("t5_y", y_out, 32'h00000001);
    check_output("t5_ones", {26'd0, ones_cnt}, 32'd1);
    check_output("t5_frame_err", {31'd0, frame_err}, 32'd0);
    drive_point();
    release_hold(1'b0);

    // Random gaps and random downstream readiness
    $display("[TB] randomised frames");
    for (int f = 0; f < 100; f++) begin
      fr = {$urandom, $urandom};
      drive_point();
      out_ready = 1'($urandom_range(0, 1));
      send_frame(fr, 8, 7, 3);
      out_ready = 1'b0;
      @(negedge clk);
      check_output("r_out_valid", {31'd0, out_valid}, 32'd1);
      check_output("r_x", x_out, fr[63:32]);
      check_output("r_y", y_out, fr[31:0]);
      check_output("r_ones", {26'd0, ones_cnt}, 32'($countones(fr[31:0])));
      drive_point();
      release_hold(1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
